// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic-light phase controller:
// state encoding, one-hot {R,Y,G} lamp codes, direction codes, lamp decoders.
package traffic_pkg;

  typedef enum logic [2:0] {
    ST_NS_GRN = 3'd0,
    ST_NS_YEL = 3'd1,
    ST_CLR    = 3'd2,
    ST_PED    = 3'd3,
    ST_EW_GRN = 3'd4,
    ST_EW_YEL = 3'd5
  } state_t;

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  localparam logic DIR_NS = 1'b0;
  localparam logic DIR_EW = 1'b1;

  function automatic logic [2:0] ns_lamp(state_t s);
    unique case (s)
      ST_NS_GRN: ns_lamp = LAMP_G;
      ST_NS_YEL: ns_lamp = LAMP_Y;
      default:   ns_lamp = LAMP_R;
    endcase
  endfunction

  function automatic logic [2:0] ew_lamp(state_t s);
    unique case (s)
      ST_EW_GRN: ew_lamp = LAMP_G;
      ST_EW_YEL: ew_lamp = LAMP_Y;
      default:   ew_lamp = LAMP_R;
    endcase
  endfunction

endpackage

// File: rtl/traffic_ctrl_if.sv
// Link between the CLK_P prescaler (master) and the phase controller (slave).
// tc_2/tc_10: held terminal-count levels; rst_q: restart of phase timing.
interface traffic_ctrl_if;
  logic tc_2;
  logic tc_10;
  logic rst_q;

  modport master (
    output tc_2,
    output tc_10,
    input  rst_q
  );

  modport slave (
    input  tc_2,
    input  tc_10,
    output rst_q
  );
endinterface

// File: rtl/traffic_ctrl_req_latch.sv
// Sticky request flag: set by i_set, cleared by i_clr (clear wins).
// Ports: i_clk, i_rst_n (async active-low), i_set, i_clr, o_q.
module req_latch (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_set,
  input  logic i_clr,
  output logic o_q
);

  logic r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)   r_q <= 1'b0;
    else if (i_clr) r_q <= 1'b0;
    else if (i_set) r_q <= 1'b1;
  end

  assign o_q = r_q;

endmodule

// File: rtl/traffic_ctrl.sv
// Traffic-light phase controller; consumer of the CLK_P terminal counts.
// Ports: i_clk, i_rst_n, tmr (tc_2/tc_10 in, rst_q out), i_ew_sense,
// i_ped_req, o_ns_light, o_ew_light, o_walk, o_state.
module traffic_ctrl
  import traffic_pkg::*;
#(
  parameter bit NS_HOLD = 1'b1,
  parameter bit PED_EN  = 1'b1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  traffic_ctrl_if.slave        tmr,
  input  logic                 i_ew_sense,
  input  logic                 i_ped_req,
  output logic [2:0]           o_ns_light,
  output logic [2:0]           o_ew_light,
  output logic                 o_walk,
  output logic [2:0]           o_state
);

  state_t     r_state;
  state_t     w_next;
  logic       r_dir;
  logic       w_dir;
  logic       r_rst_q;
  logic       w_enter;
  logic       w_ewp;
  logic       w_pedp;
  logic [2:0] r_ns;
  logic [2:0] r_ew;
  logic       r_walk;

  always_comb begin
    w_next = r_state;
    w_dir  = r_dir;
    // Terminal counts are stale during the restart cycle.
    unique case (r_state)
      ST_NS_GRN: begin
        if (!r_rst_q && tmr.tc_10 &&
            (!NS_HOLD || w_ewp || w_pedp))
          w_next = ST_NS_YEL;
      end
      ST_NS_YEL: begin
        if (!r_rst_q && tmr.tc_2) begin
          w_next = ST_CLR;
          w_dir  = DIR_EW;
        end
      end
      ST_CLR: begin
        if (!r_rst_q && tmr.tc_2) begin
          if (w_pedp)              w_next = ST_PED;
          else if (r_dir == DIR_EW) w_next = ST_EW_GRN;
          else                     w_next = ST_NS_GRN;
        end
      end
      ST_PED: begin
        if (!r_rst_q && tmr.tc_10)
          w_next = (r_dir == DIR_EW) ? ST_EW_GRN : ST_NS_GRN;
      end
      ST_EW_GRN: begin
        if (!r_rst_q && tmr.tc_10)
          w_next = ST_EW_YEL;
      end
      ST_EW_YEL: begin
        if (!r_rst_q && tmr.tc_2) begin
          w_next = ST_CLR;
          w_dir  = DIR_NS;
        end
      end
      default: begin
        // Corrupt state: fall back to all-red, then serve NS.
        w_next = ST_CLR;
        w_dir  = DIR_NS;
      end
    endcase
    w_enter = (w_next != r_state);
  end

  req_latch u_ew_pend (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_set   (i_ew_sense && (r_state != ST_EW_GRN)),
    .i_clr   (w_enter && (w_next == ST_EW_GRN)),
    .o_q     (w_ewp)
  );

  req_latch u_ped_pend (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_set   (PED_EN && i_ped_req && (r_state != ST_PED)),
    .i_clr   (w_enter && (w_next == ST_PED)),
    .o_q     (w_pedp)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_NS_GRN;
      r_dir   <= DIR_EW;
      r_rst_q <= 1'b1;
      r_ns    <= LAMP_G;
      r_ew    <= LAMP_R;
      r_walk  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_dir   <= w_dir;
      r_rst_q <= w_enter;
      r_ns    <= ns_lamp(w_next);
      r_ew    <= ew_lamp(w_next);
      r_walk  <= (w_next == ST_PED);
    end
  end

  assign tmr.rst_q  = r_rst_q;
  assign o_ns_light = r_ns;
  assign o_ew_light = r_ew;
  assign o_walk     = r_walk;
  assign o_state    = r_state;

endmodule

// File: tb/tb_traffic_ctrl.sv
// Bench for traffic_ctrl: directed vector table, reset corner cases,
// and random stimulus against a rule-level phase model (two parameter sets).
module tb_traffic_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic ew, ped, t2, t10;

  always #5 clk = ~clk;

  traffic_ctrl_if tif1();
  traffic_ctrl_if tif2();
  assign tif1.tc_2  = t2;
  assign tif1.tc_10 = t10;
  assign tif2.tc_2  = t2;
  assign tif2.tc_10 = t10;

  logic [2:0] ns1, ew1, st1, ns2, ew2, st2;
  logic       wk1, wk2;

  traffic_ctrl #(.NS_HOLD(1'b1), .PED_EN(1'b1)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .tmr(tif1.slave),
    .i_ew_sense(ew), .i_ped_req(ped),
    .o_ns_light(ns1), .o_ew_light(ew1), .o_walk(wk1), .o_state(st1));

  traffic_ctrl #(.NS_HOLD(1'b0), .PED_EN(1'b0)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .tmr(tif2.slave),
    .i_ew_sense(ew), .i_ped_req(ped),
    .o_ns_light(ns2), .o_ew_light(ew2), .o_walk(wk2), .o_state(st2));

  int n_pass = 0;
  int n_tot  = 0;

  // Phase numbers: 0 NS green, 1 NS yellow, 2 clear, 3 ped,
  // 4 EW green, 5 EW yellow. dir 1 means EW is served next.
  typedef struct {
    int ph;
    bit fresh;
    bit dir;
    bit ewp;
    bit pedp;
  } mdl_t;

  mdl_t m1, m2;

  function automatic mdl_t mreset();
    mdl_t m;
    m.ph = 0; m.fresh = 1; m.dir = 1; m.ewp = 0; m.pedp = 0;
    return m;
  endfunction

  function automatic mdl_t mstep(mdl_t m, bit hold, bit peden,
                                 bit e, bit p, bit a2, bit a10);
    mdl_t n = m;
    int nx = m.ph;
    if (!m.fresh) begin
      if (m.ph == 0 && a10 && (!hold || m.ewp || m.pedp)) nx = 1;
      if (m.ph == 1 && a2) begin nx = 2; n.dir = 1; end
      if (m.ph == 4 && a10) nx = 5;
      if (m.ph == 5 && a2) begin nx = 2; n.dir = 0; end
      if (m.ph == 2 && a2) nx = m.pedp ? 3 : (m.dir ? 4 : 0);
      if (m.ph == 3 && a10) nx = m.dir ? 4 : 0;
    end
    if (nx == 4 && m.ph != 4)  n.ewp = 0;
    else if (e && m.ph != 4)   n.ewp = 1;
    if (nx == 3 && m.ph != 3)           n.pedp = 0;
    else if (peden && p && m.ph != 3)   n.pedp = 1;
    n.fresh = (nx != m.ph);
    n.ph = nx;
    return n;
  endfunction

  function automatic logic [10:0] expo(int ph, bit rq);
    logic [2:0] s = ph[2:0];
    logic [2:0] n = (ph == 0) ? 3'b001 : (ph == 1) ? 3'b010 : 3'b100;
    logic [2:0] e = (ph == 4) ? 3'b001 : (ph == 5) ? 3'b010 : 3'b100;
    return {s, rq, (ph == 3), n, e};
  endfunction

  task automatic chk(string name, logic [10:0] act, logic [10:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s got=%h want=%h (st,rq,walk,ns,ew) t=%0t",
                  name, act, exp, $time);
  endtask

  function automatic logic [10:0] a1();
    return {st1, tif1.rst_q, wk1, ns1, ew1};
  endfunction

  function automatic logic [10:0] a2();
    return {st2, tif2.rst_q, wk2, ns2, ew2};
  endfunction

  task automatic step();
    @(posedge clk);
    if (!rst_n) begin
      m1 = mreset();
      m2 = mreset();
    end else begin
      m1 = mstep(m1, 1'b1, 1'b1, ew, ped, t2, t10);
      m2 = mstep(m2, 1'b0, 1'b0, ew, ped, t2, t10);
    end
    #1;
  endtask

  typedef struct {
    bit e, p, a2, a10;
    int st;
    bit rq;
  } vec_t;

  vec_t tbl[$];
  int   walk2_seen = 0;
  bit   reached;

  initial begin
    rst_n = 1'b0;
    ew = 0; ped = 0; t2 = 0; t10 = 1;
    m1 = mreset();
    m2 = mreset();

    // NS/ped cycle, stale-TC handling, then EW_SENSE held high.
    tbl.push_back('{0,0,0,1, 0,0});
    tbl.push_back('{0,0,0,1, 0,0});
    tbl.push_back('{1,0,0,1, 0,0});
    tbl.push_back('{0,0,0,1, 1,1});
    tbl.push_back('{0,0,1,1, 1,0});
    tbl.push_back('{0,0,0,0, 1,0});
    tbl.push_back('{0,0,1,0, 2,1});
    tbl.push_back('{0,0,1,0, 2,0});
    tbl.push_back('{0,0,1,0, 4,1});
    tbl.push_back('{0,1,0,1, 4,0});
    tbl.push_back('{0,0,0,1, 5,1});
    tbl.push_back('{0,0,1,0, 5,0});
    tbl.push_back('{0,0,1,0, 2,1});
    tbl.push_back('{0,0,0,0, 2,0});
    tbl.push_back('{0,0,1,0, 3,1});
    tbl.push_back('{0,0,0,1, 3,0});
    tbl.push_back('{0,0,0,1, 0,1});
    tbl.push_back('{0,0,0,1, 0,0});
    tbl.push_back('{0,0,0,1, 0,0});
    tbl.push_back('{1,0,1,1, 0,0});
    tbl.push_back('{1,0,1,1, 1,1});
    tbl.push_back('{1,0,1,1, 1,0});
    tbl.push_back('{1,0,1,1, 2,1});
    tbl.push_back('{1,0,1,1, 2,0});
    tbl.push_back('{1,0,1,1, 4,1});
    tbl.push_back('{1,0,1,1, 4,0});
    tbl.push_back('{1,0,1,1, 5,1});
    tbl.push_back('{1,0,1,1, 5,0});
    tbl.push_back('{1,0,1,1, 2,1});
    tbl.push_back('{1,0,1,1, 2,0});
    tbl.push_back('{1,0,1,1, 0,1});
    tbl.push_back('{1,0,1,1, 0,0});
    tbl.push_back('{1,0,1,1, 1,1});
    tbl.push_back('{0,0,0,0, 1,0});

    // Reset held with TC_10 high.
    step();
    step();
    chk("reset1", a1(), expo(0, 1));
    chk("reset2", a2(), expo(0, 1));
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      ew = tbl[i].e; ped = tbl[i].p;
      t2 = tbl[i].a2; t10 = tbl[i].a10;
      step();
      chk($sformatf("vec%0d", i), a1(), expo(tbl[i].st, tbl[i].rq));
      chk($sformatf("vec%0d_m2", i), a2(), expo(m2.ph, m2.fresh));
    end

    // Drive into EW_YEL, then reset mid-phase.
    ew = 1; ped = 0; t2 = 1; t10 = 1;
    reached = 0;
    for (int k = 0; k < 60 && !reached; k++) begin
      step();
      if (st1 == 3'd5) reached = 1;
    end
    chk("reach_ew_yel", {10'd0, reached}, 11'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst1", a1(), expo(0, 1));
    chk("midrst2", a2(), expo(0, 1));
    step();
    rst_n = 1'b1;
    ew = 0; t2 = 0; t10 = 1;
    for (int k = 0; k < 3; k++) step();
    chk("pend_discard", a1(), expo(0, 0));
    chk("pend_disc_m", a1(), expo(m1.ph, m1.fresh));

    for (int k = 0; k < 3000; k++) begin
      ew  = ($urandom_range(7) == 0);
      ped = ($urandom_range(15) == 0);
      t2  = ($urandom_range(1) == 0);
      t10 = ($urandom_range(2) == 0);
      step();
      if (wk2) walk2_seen++;
      chk("rand1", a1(), expo(m1.ph, m1.fresh));
      chk("rand2", a2(), expo(m2.ph, m2.fresh));
    end
    chk("ped_dis_walk", walk2_seen[10:0], 11'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
